// File: rtl/branch_resolve_unit_pkg.sv
// Shared core definitions for branch resolution: function codes, the 2-bit
// predictor counter type and its saturating update.
package branch_resolve_unit_pkg;

    localparam int BR_FUNC_W = 4;

    typedef enum logic [BR_FUNC_W-1:0] {
        BR_BEQ  = 4'b0000,
        BR_BNE  = 4'b0001,
        BR_BLT  = 4'b0100,
        BR_BGE  = 4'b0101,
        BR_BLTU = 4'b0110,
        BR_BGEU = 4'b0111
    } br_func_e;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_CTR_SNT   = 2'b00;
    localparam bht_ctr_t BHT_CTR_WNT   = 2'b01;
    localparam bht_ctr_t BHT_CTR_WT    = 2'b10;
    localparam bht_ctr_t BHT_CTR_ST    = 2'b11;
    localparam bht_ctr_t BHT_CTR_RESET = BHT_CTR_WNT;

    function automatic bht_ctr_t bht_ctr_next(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != BHT_CTR_ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != BHT_CTR_SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch-lookup, EX-issue and resolved-result signals of the branch resolve unit.
interface branch_resolve_unit_if #(
    parameter int WIDTH    = 32,
    parameter int PC_WIDTH = 32
);
    logic [PC_WIDTH-1:0] if_pc;
    logic                if_pred_taken;
    logic                ex_valid;
    logic                ex_stall;
    logic                ex_flush;
    logic [3:0]          ex_func;
    logic [WIDTH-1:0]    ex_in1;
    logic [WIDTH-1:0]    ex_in2;
    logic [PC_WIDTH-1:0] ex_pc;
    logic                ex_pred;
    logic                res_valid;
    logic                res_taken;
    logic                res_mispredict;
    logic [PC_WIDTH-1:0] res_pc;

    modport master (
        output if_pc, ex_valid, ex_stall, ex_flush, ex_func, ex_in1, ex_in2, ex_pc, ex_pred,
        input  if_pred_taken, res_valid, res_taken, res_mispredict, res_pc
    );

    modport slave (
        input  if_pc, ex_valid, ex_stall, ex_flush, ex_func, ex_in1, ex_in2, ex_pc, ex_pred,
        output if_pred_taken, res_valid, res_taken, res_mispredict, res_pc
    );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational evaluation of the six RV32 conditional-branch conditions.
module branch_cond_eval
    import branch_resolve_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [BR_FUNC_W-1:0] func,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    output logic                 taken,
    output logic                 legal
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (in1 == in2);
    assign lt_s = ($signed(in1) < $signed(in2));
    assign lt_u = (in1 < in2);

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (func)
            BR_BEQ:  taken = eq;
            BR_BNE:  taken = ~eq;
            BR_BLT:  taken = lt_s;
            BR_BGE:  taken = ~lt_s;
            BR_BLTU: taken = lt_u;
            BR_BGEU: taken = ~lt_u;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: registers outcome/mispredict and trains a
// direct-mapped table of 2-bit saturating counters read by fetch.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int PC_WIDTH  = 32,
    parameter int BHT_DEPTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    branch_resolve_unit_if.slave bus
);

    localparam int IDX = $clog2(BHT_DEPTH);

    logic [IDX-1:0] ex_idx;
    logic [IDX-1:0] if_idx;
    logic           cond_taken;
    logic           cond_legal;
    logic           accept;

    bht_ctr_t bht_q [BHT_DEPTH];
    bht_ctr_t bht_d [BHT_DEPTH];

    logic                res_valid_q,      res_valid_d;
    logic                res_taken_q,      res_taken_d;
    logic                res_mispredict_q, res_mispredict_d;
    logic [PC_WIDTH-1:0] res_pc_q,         res_pc_d;

    logic unused_if_pc_bits;

    branch_cond_eval #(.WIDTH(WIDTH)) u_cond_eval (
        .func  (bus.ex_func),
        .in1   (bus.ex_in1),
        .in2   (bus.ex_in2),
        .taken (cond_taken),
        .legal (cond_legal)
    );

    assign ex_idx = bus.ex_pc[IDX+1:2];
    assign if_idx = bus.if_pc[IDX+1:2];
    assign accept = bus.ex_valid & ~bus.ex_flush & ~bus.ex_stall & cond_legal;

    // Lookup reads the registered table, so a same-cycle update is not bypassed.
    assign bus.if_pred_taken = bht_q[if_idx][1];

    assign unused_if_pc_bits = ^{bus.if_pc[PC_WIDTH-1:IDX+2], bus.if_pc[1:0]};

    always_comb begin
        bht_d            = bht_q;
        res_valid_d      = 1'b0;
        res_taken_d      = 1'b0;
        res_mispredict_d = 1'b0;
        res_pc_d         = '0;
        if (bus.ex_flush) begin
            // squashed: result cleared, table untouched
        end else if (bus.ex_stall) begin
            res_valid_d      = res_valid_q;
            res_taken_d      = res_taken_q;
            res_mispredict_d = res_mispredict_q;
            res_pc_d         = res_pc_q;
        end else if (accept) begin
            res_valid_d      = 1'b1;
            res_taken_d      = cond_taken;
            res_mispredict_d = cond_taken ^ bus.ex_pred;
            res_pc_d         = bus.ex_pc;
            bht_d[ex_idx]    = bht_ctr_next(bht_q[ex_idx], cond_taken);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= BHT_CTR_RESET;
            end
            res_valid_q      <= 1'b0;
            res_taken_q      <= 1'b0;
            res_mispredict_q <= 1'b0;
            res_pc_q         <= '0;
        end else begin
            bht_q            <= bht_d;
            res_valid_q      <= res_valid_d;
            res_taken_q      <= res_taken_d;
            res_mispredict_q <= res_mispredict_d;
            res_pc_q         <= res_pc_d;
        end
    end

    assign bus.res_valid      = res_valid_q;
    assign bus.res_taken      = res_taken_q;
    assign bus.res_mispredict = res_mispredict_q;
    assign bus.res_pc         = res_pc_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed plan plus randomized
// traffic against a behavioural model of outcomes and predictor counters.
module tb_branch_resolve_unit;

    localparam int W     = 32;
    localparam int PW    = 32;
    localparam int DEPTH = 16;

    logic clk;
    logic reset;

    branch_resolve_unit_if #(.WIDTH(W), .PC_WIDTH(PW)) bus ();

    branch_resolve_unit #(.WIDTH(W), .PC_WIDTH(PW), .BHT_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int          m_ctr [DEPTH];
    bit          m_valid;
    bit          m_taken;
    bit          m_misp;
    logic [31:0] m_pc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_legal(input logic [3:0] f);
        return (f == 4'd0) || (f == 4'd1) || (f >= 4'd4 && f <= 4'd7);
    endfunction

    function automatic bit ref_taken(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (f)
            4'd0:    return ua == ub;
            4'd1:    return ua != ub;
            4'd4:    return sa < sb;
            4'd5:    return sa >= sb;
            4'd6:    return ua < ub;
            4'd7:    return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int ref_idx(input logic [31:0] pc);
        return int'((pc / 4) % DEPTH);
    endfunction

    // One clock: drive at negedge, check lookup, apply model at the edge, check results.
    task automatic step(input bit rst, input bit v, input bit st, input bit fl,
                        input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input bit pred, input logic [31:0] ifpc,
                        input string tag);
        bit t;
        reset        = rst;
        bus.ex_valid = v;
        bus.ex_stall = st;
        bus.ex_flush = fl;
        bus.ex_func  = f;
        bus.ex_in1   = a;
        bus.ex_in2   = b;
        bus.ex_pc    = pc;
        bus.ex_pred  = pred;
        bus.if_pc    = ifpc;
        #1;
        if (!rst) check({tag, ".pred"}, 64'(bus.if_pred_taken), 64'(m_ctr[ref_idx(ifpc)] >= 2));
        @(posedge clk);
        if (rst) begin
            foreach (m_ctr[i]) m_ctr[i] = 1;
            m_valid = 0; m_taken = 0; m_misp = 0; m_pc = '0;
        end else if (fl) begin
            m_valid = 0; m_taken = 0; m_misp = 0; m_pc = '0;
        end else if (st) begin
            // hold
        end else if (v && ref_legal(f)) begin
            t = ref_taken(f, a, b);
            m_valid = 1; m_taken = t; m_misp = (t != pred); m_pc = pc;
            if (t && m_ctr[ref_idx(pc)] < 3) m_ctr[ref_idx(pc)]++;
            if (!t && m_ctr[ref_idx(pc)] > 0) m_ctr[ref_idx(pc)]--;
        end else begin
            m_valid = 0; m_taken = 0; m_misp = 0; m_pc = '0;
        end
        @(negedge clk);
        check({tag, ".valid"}, 64'(bus.res_valid), 64'(m_valid));
        check({tag, ".taken"}, 64'(bus.res_taken), 64'(m_taken));
        check({tag, ".misp"},  64'(bus.res_mispredict), 64'(m_misp));
        check({tag, ".pc"},    64'(bus.res_pc), 64'(m_pc));
    endtask

    task automatic idle(input logic [31:0] ifpc, input string tag);
        step(0, 0, 0, 0, 4'd0, '0, '0, '0, 0, ifpc, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  f;
        logic [31:0] a, b, pc;
        foreach (m_ctr[i]) m_ctr[i] = 1;
        m_valid = 0; m_taken = 0; m_misp = 0; m_pc = '0;
        reset = 1'b1;
        bus.ex_valid = 0; bus.ex_stall = 0; bus.ex_flush = 0; bus.ex_func = '0;
        bus.ex_in1 = '0; bus.ex_in2 = '0; bus.ex_pc = '0; bus.ex_pred = 0; bus.if_pc = '0;
        @(negedge clk);
        step(1, 0, 0, 0, 4'd0, '0, '0, '0, 0, '0, "reset");
        check("reset.hard_pred0", 64'(bus.if_pred_taken), 64'd0);

        for (int i = 0; i < DEPTH; i++) idle(32'(i * 4), "sweep");

        // comparator sweep: 0xFFFFFFFF vs 1
        step(0, 1, 0, 0, 4'd4, 32'hFFFF_FFFF, 32'd1, 32'h100, 0, 32'h100, "blt");
        check("blt.taken_const", 64'(bus.res_taken), 64'd1);
        step(0, 1, 0, 0, 4'd5, 32'hFFFF_FFFF, 32'd1, 32'h104, 0, 32'h104, "bge");
        check("bge.taken_const", 64'(bus.res_taken), 64'd0);
        step(0, 1, 0, 0, 4'd6, 32'hFFFF_FFFF, 32'd1, 32'h108, 0, 32'h108, "bltu");
        check("bltu.taken_const", 64'(bus.res_taken), 64'd0);
        step(0, 1, 0, 0, 4'd7, 32'hFFFF_FFFF, 32'd1, 32'h10C, 0, 32'h10C, "bgeu");
        check("bgeu.taken_const", 64'(bus.res_taken), 64'd1);
        step(0, 1, 0, 0, 4'd0, 32'h1234_5678, 32'h1234_5678, 32'h110, 1, 32'h110, "beq");
        check("beq.taken_const", 64'(bus.res_taken), 64'd1);
        step(0, 1, 0, 0, 4'd1, 32'h1234_5678, 32'h1234_5678, 32'h114, 0, 32'h114, "bne");
        check("bne.taken_const", 64'(bus.res_taken), 64'd0);
        idle(32'h0, "drain");
        check("drain.valid_const", 64'(bus.res_valid), 64'd0);

        // training at 0x40: 3 taken then 3 not taken
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 4'd0, 32'd7, 32'd7, 32'h40, 1, 32'h40, "train_t");
        idle(32'h40, "train_t_after");
        check("train_t.pred_const", 64'(bus.if_pred_taken), 64'd1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 4'd1, 32'd7, 32'd7, 32'h40, 1, 32'h40, "train_nt");
        idle(32'h40, "train_nt_after");

        // mispredict: taken BEQ with pred=0
        step(0, 1, 0, 0, 4'd0, 32'd9, 32'd9, 32'h88, 0, 32'h88, "misp");
        check("misp.flag_const", 64'(bus.res_mispredict), 64'd1);
        check("misp.pc_const",   64'(bus.res_pc), 64'h88);

        // stall over a valid result for 3 cycles, then lookup
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 4'd1, 32'd1, 32'd2, 32'h88, 1, 32'h88, "stall");
        check("stall.held_const", 64'(bus.res_pc), 64'h88);
        idle(32'h88, "stall_lookup");
        step(0, 1, 0, 0, 4'd0, 32'd3, 32'd3, 32'h8C, 1, 32'h8C, "pre_flush");
        step(0, 1, 1, 1, 4'd0, 32'd3, 32'd3, 32'h8C, 1, 32'h8C, "flush_stall");
        check("flush_stall.valid_const", 64'(bus.res_valid), 64'd0);

        // illegal function code
        step(0, 1, 0, 0, 4'b0010, 32'd5, 32'd5, 32'h40, 1, 32'h40, "illegal");
        idle(32'h40, "illegal_lookup");

        // train then reset mid-run
        for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 4'd0, 32'd1, 32'd1, 32'h14, 0, 32'h14, "pre_rst");
        step(1, 1, 0, 0, 4'd0, 32'd1, 32'd1, 32'h14, 0, 32'h14, "midrst");
        for (int i = 0; i < DEPTH; i++) idle(32'(i * 4), "post_rst_sweep");
        step(0, 1, 0, 0, 4'd0, 32'd1, 32'd1, 32'h14, 0, 32'h14, "first_accept");

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 7))
                0:       f = 4'(($urandom_range(0, 1) == 0) ? 2 : $urandom_range(8, 15));
                1, 2:    f = 4'($urandom_range(0, 1));
                default: f = 4'($urandom_range(4, 7));
            endcase
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ 32'h8000_0000;
                2:       b = a + 32'($urandom_range(0, 2)) - 32'd1;
                default: b = $urandom;
            endcase
            pc = 32'($urandom_range(0, 63)) << 2;
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
                 f, a, b, pc, 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 63)) << 2, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution stage for the pipelined RV32 core. Evaluates all six RISC-V conditional-branch conditions (signed and unsigned) on EX-stage operands and registers the outcome. Compares the outcome against the fetch-time prediction to raise a mispredict. Owns a direct-mapped table of 2-bit saturating counters, read combinationally by fetch and trained on every resolved branch.

## Interface
- WIDTH, 32, operand width in bits
- PC_WIDTH, 32, program-counter width
- BHT_DEPTH, 16, number of 2-bit counters; power of two, ≥2
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- if_pc  input  PC_WIDTH  fetch-stage PC for prediction lookup
- if_pred_taken  output  1  MSB of the indexed counter; combinational
- ex_valid  input  1  EX holds a branch to resolve
- ex_stall  input  1  hold this stage
- ex_flush  input  1  squash the EX branch
- ex_func  input  4  branch function code
- ex_in1, ex_in2  input  WIDTH  rs1 and rs2 operand values
- ex_pc  input  PC_WIDTH  PC of the EX branch
- ex_pred  input  1  prediction carried from fetch
- res_valid  output  1  registered result valid
- res_taken  output  1  actual branch outcome
- res_mispredict  output  1  res_taken differs from the carried prediction
- res_pc  output  PC_WIDTH  PC of the resolved branch

## Operation
- Function codes:
  - 0000 BEQ: in1 == in2
  - 0001 BNE: in1 != in2
  - 0100 BLT: signed <
  - 0101 BGE: signed >=
  - 0110 BLTU: unsigned <
  - 0111 BGEU: unsigned >=
  - Any other code is illegal.
- Comparisons use the full WIDTH bits. Signed means two's complement.
- Index = pc[IDX+1:2], where IDX = log2(BHT_DEPTH). Bits [1:0] are ignored.
- Counter encoding:
  - 00 strong-not-taken
  - 01 weak-not-taken
  - 10 weak-taken
  - 11 strong-taken
- Predict taken when the counter MSB is 1.
- A branch is accepted when ex_valid=1, ex_flush=0, ex_stall=0 and the function code is legal. On acceptance:
  - Outcome is captured into res_*.
  - res_valid goes to 1.
  - Counter[index(ex_pc)] increments if taken, decrements if not, saturating at 11 and at 00.
- Clock-edge priority, highest first:
  1. reset: res_* cleared to 0; every counter set to 01.
  2. ex_flush: res_valid=0; no counter update.
  3. ex_stall: all res_* and counters hold.
  4. Accept, as above.
  5. Otherwise, including an illegal code: res_valid=0; no counter update.
- When res_valid=0, res_taken, res_mispredict and res_pc are 0.

## Timing
- Resolution latency is 1 cycle: accept at edge N, res_* valid after edge N.
- res_valid stays high only for cycles following an accepting edge. A stall holds the previous result, including a held res_valid=1.
- if_pred_taken is zero-latency combinational from if_pc and the counter array.
- Read and update of the same index in one cycle: if_pred_taken shows the pre-update value. No bypass. The new value is visible the cycle after the edge.
- Reset asserted mid-stream: the next edge clears everything. After reset drops, the first accept may occur on the first edge.
- Reset-asserted output values: res_valid=0, res_taken=0, res_mispredict=0, res_pc=0. if_pred_taken=0, since all counters are 01.

## Structure
- The shared core package holds:
  - function-code constants: BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU
  - the 2-bit counter typedef
  - the counter reset constant 01
- One sub-module, branch_cond_eval: purely combinational; inputs func, in1, in2; outputs taken and legal; parametrised by WIDTH.
- The top level holds the counter array, the update logic and the res_* registers.

## Test plan
- Reset, then sweep if_pc over all 16 indices: if_pred_taken=0 for each. Assert reset mid-run after training: all counters return to 01 and res_valid=0.
- Comparator sweep, in1=0xFFFF_FFFF, in2=0x0000_0001:
  - BLT taken, BGE not taken, BLTU not taken, BGEU taken.
  - BEQ and BNE with equal operands: BEQ taken, BNE not taken.
  - Each result appears exactly one cycle after the accepting edge.
- Training on the same ex_pc=0x40:
  - 3 taken branches: counter path 01→10→11→11; if_pred_taken at 0x40 becomes 1 after the first edge.
  - Then 3 not-taken: counter path 11→10→01→00.
- Mispredict: ex_pred=0 with a taken BEQ gives res_mispredict=1 and res_pc=ex_pc.
- Stall held for 3 cycles over a valid result: res_* unchanged; counter unchanged, checked by a following lookup. Flush and stall in the same cycle: res_valid=0 next cycle.
- Illegal function code 0010 with ex_valid=1: res_valid=0; counter at the index unchanged.
